// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state type, special key codes and the {col,row} key map
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_e;

  localparam logic [3:0] KEY_CLEAR   = 4'hF;
  localparam logic [3:0] KEY_CONFIRM = 4'hE;
  localparam logic [3:0] ALL_HIGH    = 4'hF;

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    return v == 4'b0111 ? 2'd0 : v == 4'b1011 ? 2'd1 : v == 4'b1101 ? 2'd2 : 2'd3;
  endfunction

  function automatic logic one_low(input logic [3:0] v);
    return $countones(~v) == 1;
  endfunction

  // Columns 0..2 are the numeric grid plus F/0/E on the bottom row; column 3 is A..D.
  function automatic logic [3:0] key_map(input logic [3:0] c, input logic [3:0] r);
    logic [1:0] ci;
    logic [1:0] ri;
    ci = low_idx(c);
    ri = low_idx(r);
    if (ci == 2'd3) return 4'hA + {2'b00, ri};
    if (ri == 2'd3) return ci == 2'd0 ? KEY_CLEAR : ci == 2'd1 ? 4'h0 : KEY_CONFIRM;
    return {2'b00, ri} * 4'd3 + {2'b00, ci} + 4'd1;
  endfunction

endpackage

// File: rtl/keypad_tick.sv
// keypad_tick: one-clk scan tick every SCAN_DIV cycles while enabled
module keypad_tick #(
  parameter int SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int W = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && cnt_q == W'(SCAN_DIV - 1);

  // free-running divider, parked at zero while scanning is disabled
  always_comb cnt_d = (!en || tick) ? '0 : cnt_q + 1'b1;

  // divider register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low keypad scanner with press/release debounce
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int DEBOUNCE_N = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int            CW      = $clog2(DEBOUNCE_N + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_N);

  state_e        state_q, state_d;
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    col_q, col_d;
  logic [3:0]    lrow_q, lrow_d;
  logic [3:0]    code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          valid_q, valid_d;
  logic          tick, hit, match;

  keypad_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );

  assign hit       = sync2_q != ALL_HIGH;
  assign match     = sync2_q == lrow_q && one_low(sync2_q);
  assign cnt_inc   = cnt_q == CNT_MAX ? CNT_MAX : cnt_q + 1'b1;
  assign col       = col_q;
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_held  = state_q == ST_PRESSED || state_q == ST_RELEASE;

  // scan FSM: moves only on tick, except that dropping en forces IDLE at once
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    lrow_d  = lrow_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      col_d   = '0;
      cnt_d   = '0;
    end else if (tick) begin
      case (state_q)
        ST_IDLE:
          if (hit) begin
            state_d = ST_SCAN;
            col_d   = 4'b0111;
          end
        ST_SCAN:
          if (hit) begin
            state_d = ST_DEBOUNCE;
            lrow_d  = sync2_q;
            cnt_d   = '0;
          end else if (col_q == 4'b1110) begin
            state_d = ST_IDLE;
            col_d   = '0;
          end else col_d = {1'b1, col_q[3:1]};
        ST_DEBOUNCE:
          if (!match) begin
            state_d = ST_IDLE;
            col_d   = '0;
          end else if (cnt_inc == CNT_MAX) begin
            state_d = ST_PRESSED;
            cnt_d   = cnt_inc;
            valid_d = 1'b1;
            code_d  = key_map(col_q, lrow_q);
          end else cnt_d = cnt_inc;
        ST_PRESSED:
          if (!hit) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
          end
        ST_RELEASE:
          if (hit) cnt_d = '0;
          else if (cnt_inc == CNT_MAX) begin
            state_d = ST_IDLE;
            col_d   = '0;
            cnt_d   = '0;
          end else cnt_d = cnt_inc;
        default: begin
          state_d = ST_IDLE;
          col_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // row synchronizer idles at all-released so reset never looks like a press
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1_q <= ALL_HIGH;
      sync2_q <= ALL_HIGH;
    end else begin
      sync1_q <= row;
      sync2_q <= sync1_q;
    end

  // FSM and output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      lrow_q  <= ALL_HIGH;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      lrow_q  <= lrow_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: keypad model driving keypad_scan, scoreboard of expected key codes
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_held;

  logic       key_on = 1'b0;
  logic [3:0] key_c  = 4'hF;
  logic [3:0] key_r  = 4'hF;

  int         n_chk  = 0;
  int         n_pass = 0;
  int         n_pulse = 0;
  logic       kv_prev = 1'b0;
  logic [3:0] exp_q[$];

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_N(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .row      (row),
    .col      (col),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // a pressed key shorts its row low whenever its column is driven low
  assign row = (key_on && ((~col & ~key_c) != 4'h0)) ? key_r : 4'hF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic ticks(input int n);
    repeat (n * 4) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] c, input logic [3:0] r);
    key_c  = c;
    key_r  = r;
    key_on = 1'b1;
  endtask

  // pulse monitor: pops the scoreboard on every key_valid and checks pulse width
  always @(negedge clk) begin
    if (kv_prev) chk("kv_width", key_valid, 0);
    if (key_valid) begin
      n_pulse++;
      chk("held_at_pulse", key_held, 1);
      if (exp_q.size() == 0) chk("unexp_pulse", key_valid, 0);
      else chk("code", key_code, exp_q.pop_front());
    end
    kv_prev = key_valid;
  end

  initial begin
    int   p0;
    logic seen;
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_col", col, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_held", key_held, 0);
    rst = 1'b0;
    ticks(3);
    chk("idle_col", col, 0);

    // key 5 held for 20 ticks, then release debounce
    p0 = n_pulse;
    exp_q.push_back(4'h5);
    press(4'b1011, 4'b1011);
    ticks(20);
    chk("s1_pulses", n_pulse - p0, 1);
    chk("s1_code", key_code, 5);
    chk("s1_held", key_held, 1);
    key_on = 1'b0;
    repeat (12) @(negedge clk);
    chk("s1_held_rel", key_held, 1);
    repeat (8) @(negedge clk);
    chk("s1_held_off", key_held, 0);
    chk("s1_code_kept", key_code, 5);
    ticks(4);
    chk("s1_idle_col", col, 0);

    // key E bouncing for 4 ticks, then stable
    p0 = n_pulse;
    exp_q.push_back(4'hE);
    press(4'b1101, 4'b1110);
    for (int i = 0; i < 4; i++) begin
      ticks(1);
      key_on = ~key_on;
    end
    chk("s2_bounce_nopulse", n_pulse - p0, 0);
    key_on = 1'b1;
    ticks(16);
    chk("s2_pulses", n_pulse - p0, 1);
    chk("s2_code", key_code, 4'hE);
    key_on = 1'b0;
    ticks(8);
    chk("s2_released", key_held, 0);

    // two rows low in one column: never accepted
    p0   = n_pulse;
    seen = 1'b0;
    press(4'b0111, 4'b0011);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (key_held) seen = 1'b1;
    end
    chk("s3_pulses", n_pulse - p0, 0);
    chk("s3_held", seen, 0);
    key_on = 1'b0;
    ticks(6);
    chk("s3_idle_col", col, 0);

    // en dropped while debouncing key 8
    p0   = n_pulse;
    seen = 1'b0;
    press(4'b1011, 4'b1101);
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (col == 4'b1011) seen = 1'b1;
    end
    chk("s4_col_seen", seen, 1);
    repeat (6) @(negedge clk);
    chk("s4_deb_col", col, 4'b1011);
    en = 1'b0;
    @(negedge clk);
    chk("s4_col_off", col, 0);
    chk("s4_valid", key_valid, 0);
    chk("s4_held", key_held, 0);
    ticks(6);
    chk("s4_pulses", n_pulse - p0, 0);
    chk("s4_code_kept", key_code, 4'hE);
    key_on = 1'b0;
    @(negedge clk);
    en = 1'b1;
    ticks(4);

    // reset while key F is pressed, key still held afterwards
    p0 = n_pulse;
    exp_q.push_back(KEY_F());
    press(4'b0111, 4'b1110);
    ticks(12);
    chk("s5_pulses", n_pulse - p0, 1);
    chk("s5_held", key_held, 1);
    #2 rst = 1'b1;
    #1;
    chk("s5_rst_col", col, 0);
    chk("s5_rst_code", key_code, 0);
    chk("s5_rst_held", key_held, 0);
    chk("s5_rst_valid", key_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    p0  = n_pulse;
    exp_q.push_back(KEY_F());
    ticks(14);
    chk("s5_repulse", n_pulse - p0, 1);
    chk("s5_code", key_code, 4'hF);
    key_on = 1'b0;
    ticks(8);
    chk("s5_after_rel", n_pulse - p0, 1);

    // key D needs the scan to reach the last column
    p0   = n_pulse;
    seen = 1'b0;
    exp_q.push_back(4'hD);
    press(4'b1110, 4'b1110);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (col == 4'b1110) seen = 1'b1;
    end
    chk("s6_col4", seen, 1);
    chk("s6_pulses", n_pulse - p0, 1);
    chk("s6_code", key_code, 4'hD);
    key_on = 1'b0;
    ticks(8);
    chk("s6_held_off", key_held, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  function automatic logic [3:0] KEY_F();
    return 4'hF;
  endfunction

endmodule
